// File: rtl/reg_file_pkg.sv
// Shared types and constants for the live-value-table register file.
`ifndef NUM_PR
`define NUM_PR 64
`endif

package reg_file_pkg;

  // Physical register address as seen by rename/issue
  typedef logic [$clog2(`NUM_PR)-1:0] paddr_t;

  // INIT clears every entry once after reset; RUN is normal service
  typedef enum logic {
    RF_INIT,
    RF_RUN
  } rf_state_e;

  // Bits needed to name a write port, never narrower than one bit
  function automatic int lvt_width(input int num_write);
    return (num_write > 1) ? $clog2(num_write) : 1;
  endfunction

  // LVT entry width for the default two-write-port configuration
  localparam int LVT_W = lvt_width(2);

endpackage

// File: rtl/sdp_bram_bank.sv
// Simple dual-port RAM bank: one write port, one synchronous read port.
// A read and write to the same address in one cycle returns the old data.
module sdp_bram_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array write; contents are deliberately not reset so this maps to BRAM
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read, sees the array value from before this edge's write
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lvt_reg_file.sv
// Multi-ported register file built from one BRAM bank per (write, read)
// port pair. A flop-based live-value table remembers which write port
// last wrote each entry and steers every read to that port's bank.
module lvt_reg_file
  import reg_file_pkg::*;
#(
  parameter int NUM_WRITE = 2,
  parameter int NUM_READ  = 4,
  parameter int DEPTH     = `NUM_PR,
  parameter int WIDTH     = 32,
  parameter int ZERO_REG  = 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  output logic                                     ready,
  input  logic [NUM_WRITE-1:0]                     we,
  input  logic [NUM_WRITE-1:0][$clog2(DEPTH)-1:0]  waddr,
  input  logic [NUM_WRITE-1:0][WIDTH-1:0]          wdata,
  input  logic [NUM_READ-1:0]                      re,
  input  logic [NUM_READ-1:0][$clog2(DEPTH)-1:0]   raddr,
  output logic [NUM_READ-1:0][WIDTH-1:0]           rdata,
  output logic [NUM_READ-1:0]                      rvalid
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int LVT_BITS = lvt_width(NUM_WRITE);

  rf_state_e state, state_next;
  logic [CW-1:0] cnt;
  logic run;

  logic [LVT_BITS-1:0] lvt [DEPTH];

  logic [NUM_WRITE-1:0]           wr_ok;
  logic [NUM_WRITE-1:0]           bank_we;
  logic [NUM_WRITE-1:0][AW-1:0]   bank_waddr;
  logic [NUM_WRITE-1:0][WIDTH-1:0] bank_wdata;
  logic [NUM_READ-1:0]            rd_en;
  logic [WIDTH-1:0]               bank_dout [NUM_WRITE][NUM_READ];

  logic [NUM_READ-1:0]              byp_hit;
  logic [NUM_READ-1:0][WIDTH-1:0]   byp_data;

  logic [NUM_READ-1:0]                re_q;
  logic [NUM_READ-1:0]                hit_q;
  logic [NUM_READ-1:0]                zero_q;
  logic [NUM_READ-1:0][WIDTH-1:0]     byp_q;
  logic [NUM_READ-1:0][LVT_BITS-1:0]  sel_q;

  assign run   = (state == RF_RUN);
  assign ready = run;

  // State register and init sweep counter; reset restarts the sweep
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RF_INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == RF_INIT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Leave INIT once the last address has been cleared
  always_comb begin
    state_next = state;
    if (state == RF_INIT && cnt == CW'(DEPTH - 1)) begin
      state_next = RF_RUN;
    end
  end

  // A user write takes effect only in RUN and never to the hard-wired zero entry
  always_comb begin
    for (int w = 0; w < NUM_WRITE; w++) begin
      wr_ok[w] = run && we[w] && !((ZERO_REG != 0) && (waddr[w] == '0));
    end
  end

  // Bank write ports; during INIT port 0's banks are hijacked to clear memory
  always_comb begin
    for (int w = 0; w < NUM_WRITE; w++) begin
      bank_we[w]    = wr_ok[w];
      bank_waddr[w] = waddr[w];
      bank_wdata[w] = wdata[w];
    end
    if (state == RF_INIT) begin
      bank_we[0]    = 1'b1;
      bank_waddr[0] = cnt[AW-1:0];
      bank_wdata[0] = '0;
    end
  end

  // Live-value table; ascending loop lets the highest port index win a conflict
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        lvt[i] <= '0;
      end
    end else if (state == RF_INIT) begin
      lvt[cnt[AW-1:0]] <= '0;
    end else begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wr_ok[w]) begin
          lvt[waddr[w]] <= LVT_BITS'(w);
        end
      end
    end
  end

  // Same-cycle write-to-read forwarding, highest write port wins
  always_comb begin
    for (int r = 0; r < NUM_READ; r++) begin
      byp_hit[r]  = 1'b0;
      byp_data[r] = '0;
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (wr_ok[w] && waddr[w] == raddr[r]) begin
          byp_hit[r]  = 1'b1;
          byp_data[r] = wdata[w];
        end
      end
    end
  end

  // Bank reads are only issued for enabled requests in RUN
  always_comb begin
    for (int r = 0; r < NUM_READ; r++) begin
      rd_en[r] = run && re[r];
    end
  end

  // Read request pipeline: owner from the LVT, bypass data and qualifiers
  always_ff @(posedge clk) begin
    if (reset) begin
      re_q   <= '0;
      hit_q  <= '0;
      zero_q <= '0;
      byp_q  <= '0;
      sel_q  <= '0;
    end else begin
      for (int r = 0; r < NUM_READ; r++) begin
        re_q[r]   <= rd_en[r];
        hit_q[r]  <= byp_hit[r];
        byp_q[r]  <= byp_data[r];
        sel_q[r]  <= lvt[raddr[r]];
        zero_q[r] <= (ZERO_REG != 0) && (raddr[r] == '0);
      end
    end
  end

  for (genvar w = 0; w < NUM_WRITE; w++) begin : g_wr
    for (genvar r = 0; r < NUM_READ; r++) begin : g_rd
      sdp_bram_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_bank (
        .clk   (clk),
        .we    (bank_we[w]),
        .waddr (bank_waddr[w]),
        .wdata (bank_wdata[w]),
        .re    (rd_en[r]),
        .raddr (raddr[r]),
        .rdata (bank_dout[w][r])
      );
    end
  end

  // Output select: idle and zero reads give 0, then bypass, then owning bank
  always_comb begin
    for (int r = 0; r < NUM_READ; r++) begin
      rvalid[r] = re_q[r];
      rdata[r]  = '0;
      if (re_q[r] && !zero_q[r]) begin
        if (hit_q[r]) begin
          rdata[r] = byp_q[r];
        end else begin
          for (int w = 0; w < NUM_WRITE; w++) begin
            if (sel_q[r] == LVT_BITS'(w)) begin
              rdata[r] = bank_dout[w][r];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lvt_reg_file.sv
// Directed self-checking bench for lvt_reg_file (2 write, 4 read, 64 deep).
module tb_lvt_reg_file;

  logic             clk;
  logic             reset;
  logic             ready;
  logic [1:0]       we;
  logic [1:0][5:0]  waddr;
  logic [1:0][31:0] wdata;
  logic [3:0]       re;
  logic [3:0][5:0]  raddr;
  logic [3:0][31:0] rdata;
  logic [3:0]       rvalid;

  int errors = 0;
  int checks = 0;
  int n;

  lvt_reg_file #(
    .NUM_WRITE (2),
    .NUM_READ  (4),
    .DEPTH     (64),
    .WIDTH     (32),
    .ZERO_REG  (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ready  (ready),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .re     (re),
    .raddr  (raddr),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of write/read requests and clock it in
  task automatic applyStimulus(
    input logic [1:0]  we_v,
    input logic [5:0]  wa0, input logic [31:0] wd0,
    input logic [5:0]  wa1, input logic [31:0] wd1,
    input logic [3:0]  re_v,
    input logic [5:0]  ra0, input logic [5:0] ra1,
    input logic [5:0]  ra2, input logic [5:0] ra3
  );
    we       = we_v;
    waddr[0] = wa0;
    wdata[0] = wd0;
    waddr[1] = wa1;
    wdata[1] = wd1;
    re       = re_v;
    raddr[0] = ra0;
    raddr[1] = ra1;
    raddr[2] = ra2;
    raddr[3] = ra3;
    tick();
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Count edges until ready rises, bounded so a stuck sweep cannot hang
  task automatic waitReady(output int cycles);
    cycles = 0;
    while (ready !== 1'b1 && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    reset = 1'b1;
    we = '0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    tick();
    tick();
    checkOutput("reset_ready", 128'(ready), 128'(1'b0));
    checkOutput("reset_rvalid", 128'(rvalid), 128'(4'h0));
    checkOutput("reset_rdata", 128'(rdata), 128'h0);

    // Release reset between edges; the sweep needs exactly 64 edges
    reset = 1'b0;
    waitReady(n);
    checkOutput("init_sweep_len", 128'(n), 128'(64));

    // Memory reads back as zero after the sweep
    applyStimulus(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 4'b1111, 6'd3, 6'd17, 6'd40, 6'd63);
    checkOutput("init_rd0", 128'(rdata[0]), 128'h0);
    checkOutput("init_rd1", 128'(rdata[1]), 128'h0);
    checkOutput("init_rd2", 128'(rdata[2]), 128'h0);
    checkOutput("init_rd3", 128'(rdata[3]), 128'h0);
    checkOutput("init_rvalid", 128'(rvalid), 128'(4'hF));

    // Two-port write with no reads: outputs idle
    applyStimulus(2'b11, 6'd5, 32'hDEADBEEF, 6'd9, 32'h12345678, 4'b0000, 6'd5, 6'd9, 6'd5, 6'd9);
    checkOutput("idle_rvalid", 128'(rvalid), 128'(4'h0));
    checkOutput("idle_rdata", 128'(rdata), 128'h0);

    applyStimulus(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 4'b1111, 6'd5, 6'd9, 6'd5, 6'd9);
    checkOutput("wr_rd0", 128'(rdata[0]), 128'hDEADBEEF);
    checkOutput("wr_rd1", 128'(rdata[1]), 128'h12345678);
    checkOutput("wr_rd2", 128'(rdata[2]), 128'hDEADBEEF);
    checkOutput("wr_rd3", 128'(rdata[3]), 128'h12345678);
    checkOutput("wr_rvalid", 128'(rvalid), 128'(4'hF));

    // Ownership of addr 7 moves port0 -> port1 -> port0
    applyStimulus(2'b01, 6'd7, 32'h0000AAAA, 6'd0, 32'h0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    applyStimulus(2'b10, 6'd0, 32'h0, 6'd7, 32'h0000BBBB, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    applyStimulus(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 4'b0001, 6'd7, 6'd0, 6'd0, 6'd0);
    checkOutput("lvt_port1_owns", 128'(rdata[0]), 128'h0000BBBB);
    applyStimulus(2'b01, 6'd7, 32'h0000CCCC, 6'd0, 32'h0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    applyStimulus(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 4'b0010, 6'd0, 6'd7, 6'd0, 6'd0);
    checkOutput("lvt_port0_owns", 128'(rdata[1]), 128'h0000CCCC);

    // Same-address conflict: port1 wins
    applyStimulus(2'b11, 6'd12, 32'h00001111, 6'd12, 32'h00002222, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    applyStimulus(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 4'b1000, 6'd0, 6'd0, 6'd0, 6'd12);
    checkOutput("conflict_rd", 128'(rdata[3]), 128'h00002222);

    // Bypass: write and read of addr 20 in the same cycle
    applyStimulus(2'b10, 6'd0, 32'h0, 6'd20, 32'h5A5A5A5A, 4'b0100, 6'd0, 6'd0, 6'd20, 6'd0);
    checkOutput("bypass_rd2", 128'(rdata[2]), 128'h5A5A5A5A);
    checkOutput("bypass_rvalid", 128'(rvalid), 128'(4'b0100));

    // Bypass with a same-cycle conflict forwards the winning port
    applyStimulus(2'b11, 6'd25, 32'h00000033, 6'd25, 32'h00000044, 4'b0001, 6'd25, 6'd0, 6'd0, 6'd0);
    checkOutput("bypass_conflict", 128'(rdata[0]), 128'h00000044);

    // The bypassed write also landed in the banks
    applyStimulus(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 4'b0010, 6'd0, 6'd20, 6'd0, 6'd0);
    checkOutput("bypass_stored", 128'(rdata[1]), 128'h5A5A5A5A);

    // Zero register: writes dropped, reads return 0 with rvalid
    applyStimulus(2'b01, 6'd0, 32'hFFFFFFFF, 6'd0, 32'h0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    applyStimulus(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 4'b0010, 6'd0, 6'd0, 6'd0, 6'd0);
    checkOutput("zero_rd", 128'(rdata[1]), 128'h0);
    checkOutput("zero_rvalid", 128'(rvalid), 128'(4'b0010));
    applyStimulus(2'b10, 6'd0, 32'h0, 6'd0, 32'hFFFFFFFF, 4'b0001, 6'd0, 6'd0, 6'd0, 6'd0);
    checkOutput("zero_bypass", 128'(rdata[0]), 128'h0);

    // Reset, run 30 sweep cycles with reads requested, then reset again
    reset = 1'b1;
    applyStimulus(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd0);
    reset = 1'b0;
    re = 4'b1111;
    for (int i = 0; i < 30; i++) begin
      tick();
    end
    checkOutput("sweep_ready_low", 128'(ready), 128'(1'b0));
    checkOutput("sweep_reads_ignored", 128'(rvalid), 128'(4'h0));
    re = 4'b0000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    waitReady(n);
    checkOutput("resweep_len", 128'(n), 128'(64));

    // Earlier contents were cleared by the fresh sweep
    applyStimulus(2'b00, 6'd0, 32'h0, 6'd0, 32'h0, 4'b0011, 6'd5, 6'd9, 6'd0, 6'd0);
    checkOutput("resweep_rd5", 128'(rdata[0]), 128'h0);
    checkOutput("resweep_rd9", 128'(rdata[1]), 128'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lvt_reg_file.md
Name: lvt_reg_file

Overview:
- Parametrised physical register file with NUM_WRITE write ports and NUM_READ read ports per cycle.
- Built from one simple-dual-port BRAM bank per (write port, read port) pair.
- A flop-based live-value table (LVT) records which write port last wrote each entry, and steers every read to that port's bank.
- Sits between rename/issue and the execution lanes. It replaces the mode-multiplexed BRAM register file, so reads and writes happen in the same cycle with no mode selection.

Parameters:
- NUM_WRITE, 2, number of write ports (>=1).
- NUM_READ, 4, number of read ports (>=1).
- DEPTH, `NUM_PR, number of physical registers (power of two).
- WIDTH, 32, data width.
- ZERO_REG, 1, if 1 then address 0 always reads 0 and writes to it are dropped.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- ready  output  1  high once initialisation sweep completes
- we  input  [NUM_WRITE]x1  write enable per port
- waddr  input  [NUM_WRITE]x$clog2(DEPTH)  write address per port
- wdata  input  [NUM_WRITE]xWIDTH  write data per port
- re  input  [NUM_READ]x1  read enable per port
- raddr  input  [NUM_READ]x$clog2(DEPTH)  read address per port
- rdata  output  [NUM_READ]xWIDTH  read data, one cycle after request
- rvalid  output  [NUM_READ]x1  rdata valid qualifier

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset:
  - State goes to INIT, the init counter goes to 0, and every LVT entry goes to 0.
  - ready=0, rvalid=0, rdata=0.
  - BRAM contents are not reset directly; the INIT sweep clears them.
- FSM states INIT and RUN.
  - INIT: each cycle, write 0 at address cnt into all banks of write port 0 and set LVT[cnt]=0. cnt increments.
  - INIT to RUN: after cnt==DEPTH-1 is written, the next state is RUN and ready=1 from that cycle on. The sweep takes exactly DEPTH cycles after reset deasserts.
  - INIT: user we/re are ignored and rvalid stays 0.
  - RUN: normal operation. RUN persists until reset.
  - Reset mid-sweep restarts the sweep from cnt=0.
- Write (RUN), for each port w with we[w]=1:
  - Write wdata[w] at waddr[w] into banks [w][0..NUM_READ-1].
  - Set LVT[waddr[w]]=w at the clock edge.
- Write conflicts and dropped writes:
  - If two ports write the same address in the same cycle, the highest port index wins, for both the data and the LVT entry.
  - With ZERO_REG=1, a write to address 0 is dropped: no bank write and no LVT update.
- Read (RUN), fixed latency 1:
  - At edge N, latch raddr[r], re[r], and LVT[raddr[r]] as read before any edge-N update.
  - At N+1, rdata[r] = bank[LVT value][r] output and rvalid[r] = latched re[r].
- Read bypass (write-first):
  - If in the request cycle any enabled write port has waddr==raddr[r], rdata[r] at N+1 returns that cycle's winning wdata.
  - This applies even though the BRAM read returns old data; the bypass mux must register the write data and a hit flag.
- Idle and zero reads:
  - If re[r]=0, then rvalid[r]=0 and rdata[r]=0.
  - With ZERO_REG=1, a read of address 0 returns 0 with rvalid per re.
- Register widths:
  - LVT entries are $clog2(NUM_WRITE) bits, with minimum 1.
  - The init counter is $clog2(DEPTH)+1 bits.
- Invariant: rdata never reflects the bank of a write port that does not own the entry per the LVT.

Decomposition:
- Shared package reg_file_pkg:
  - paddr_t (logic [$clog2(`NUM_PR)-1:0]).
  - The FSM state enum rf_state_e {RF_INIT, RF_RUN}.
  - Localparam LVT_W.
- Sub-module sdp_bram_bank:
  - Parameters WIDTH and DEPTH; one write port, one synchronous read port, read-old-data on collision, no reset of the array.
  - Instantiated NUM_WRITE*NUM_READ times in a generate loop.
- The LVT, FSM, and bypass logic stay in lvt_reg_file.

Test Plan:
- Init sweep: with DEPTH=64, release reset -> ready=0 for exactly 64 cycles, then 1. Reading any address afterwards returns 0x00000000 with rvalid=1.
- Write then read: port0 writes 0xDEADBEEF at addr 5 and port1 writes 0x12345678 at addr 9. Next cycle, read ports 0-3 read 5, 9, 5, 9 -> one cycle later rdata = DEADBEEF, 12345678, DEADBEEF, 12345678.
- LVT ownership:
  - Port0 writes 0xAAAA at addr 7; a later cycle port1 writes 0xBBBB at addr 7 -> a read of 7 returns 0xBBBB.
  - Port0 then rewrites 0xCCCC -> a read of 7 returns 0xCCCC.
- Same-address conflict: port0 writes 0x1111 and port1 writes 0x2222, both at addr 12 in the same cycle -> a subsequent read returns 0x2222.
- Bypass: in a single cycle, port1 writes 0x5A5A5A5A at addr 20 while read port 2 reads addr 20 -> next cycle rdata[2]=0x5A5A5A5A, rvalid[2]=1.
- Zero register and mid-sweep reset:
  - Writing 0xFFFFFFFF to addr 0 -> a read of 0 returns 0.
  - Asserting reset at sweep cycle 30 -> ready stays 0 for a further 64 cycles after release.
